dmem_ext: RTL and testbench

DMEM_EXT -- requirements
Module: dmem_ext

---
 rtl/dmem_ext_if.sv | 37 +++
 rtl/dmem_ext.sv | 178 +++++++++++++++++
 tb/tb_dmem_ext.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ext_if.sv
// Request/response bus between a load/store requester and the dmem_ext data memory.
// The master drives requests; the slave (memory) answers with a one-cycle response strobe.
interface dmem_ext_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        resp_valid;
    logic [31:0] read_data;
    logic        resp_err;

    modport master (
        output req_valid,
        output req_we,
        output req_funct3,
        output addr,
        output write_data,
        input  req_ready,
        input  resp_valid,
        input  read_data,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_funct3,
        input  addr,
        input  write_data,
        output req_ready,
        output resp_valid,
        output read_data,
        output resp_err
    );
endinterface

// File: rtl/dmem_ext.sv
// RV32I-style byte-addressable data memory with fixed response latency.
// Stores commit and loads sample at the accept edge; the result is replayed LATENCY cycles later.
module dmem_ext #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic     clk,
    input  logic     rst,
    dmem_ext_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] CNT_INIT = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [1:0]  cnt_r;
    logic        err_r;
    logic [31:0] rdata_r;
    logic [31:0] mem_r [DEPTH];

    logic          ready_s;
    logic          resp_valid_s;
    logic          resp_err_s;
    logic [31:0]   read_data_s;
    logic          accept_s;
    logic [AW-1:0] idx_s;
    logic [1:0]    off_s;
    logic          legal_s;
    logic [3:0]    be_s;
    logic [31:0]   wdata_sh_s;
    logic [31:0]   word_s;
    logic [31:0]   load_s;
    logic          unused_addr_s;

    // Legal funct3/offset combinations; loads additionally allow the unsigned variants.
    function automatic logic legal_access(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = (off[0] == 1'b0);
            3'b010:  ok = (off == 2'b00);
            3'b100:  ok = !we;
            3'b101:  ok = !we && (off[0] == 1'b0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  res = {{24{sh[7]}}, sh[7:0]};
            3'b001:  res = {{16{sh[15]}}, sh[15:0]};
            3'b010:  res = word;
            3'b100:  res = {24'd0, sh[7:0]};
            3'b101:  res = {16'd0, sh[15:0]};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    // Address bits above the word index are ignored so accesses wrap modulo DEPTH.
    assign idx_s         = bus.addr[AW+1:2];
    assign off_s         = bus.addr[1:0];
    assign unused_addr_s = ^bus.addr[31:AW+2];
    assign accept_s      = bus.req_valid && ready_s;
    assign legal_s       = legal_access(bus.req_we, bus.req_funct3, off_s);
    assign be_s          = byte_enables(bus.req_funct3, off_s);
    assign wdata_sh_s    = bus.write_data << {off_s, 3'b000};
    assign word_s        = mem_r[idx_s];
    assign load_s        = load_extend(bus.req_funct3, off_s, word_s);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = (LATENCY == 1) ? RESP : WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 2'd0) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: response fields are forced to zero outside the RESP cycle.
    always_comb begin
        ready_s      = 1'b0;
        resp_valid_s = 1'b0;
        resp_err_s   = 1'b0;
        read_data_s  = 32'd0;
        case (state_r)
            IDLE: begin
                ready_s = !rst;
            end
            WAIT: begin
                ready_s = 1'b0;
            end
            RESP: begin
                resp_valid_s = 1'b1;
                resp_err_s   = err_r;
                read_data_s  = rdata_r;
            end
            default: begin
                ready_s = 1'b0;
            end
        endcase
    end

    // Latency counter plus the response captured at accept (zero data for stores and errors).
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= 2'd0;
            err_r   <= 1'b0;
            rdata_r <= 32'd0;
        end else if (accept_s) begin
            cnt_r   <= CNT_INIT;
            err_r   <= !legal_s;
            rdata_r <= (legal_s && !bus.req_we) ? load_s : 32'd0;
        end else if ((state_r == WAIT) && (cnt_r != 2'd0)) begin
            cnt_r <= cnt_r - 2'd1;
        end
    end

    // Storage array; reset deliberately leaves contents intact.
    always_ff @(posedge clk) begin
        if (accept_s && bus.req_we && legal_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_r[idx_s][8*b +: 8] <= wdata_sh_s[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = ready_s;
    assign bus.resp_valid = resp_valid_s;
    assign bus.resp_err   = resp_err_s;
    assign bus.read_data  = read_data_s;
endmodule

// File: tb/tb_dmem_ext.sv
// Bench for dmem_ext: a LATENCY=1/DEPTH=1024 and a LATENCY=3/DEPTH=16 instance, each
// checked against a word-array reference model derived from the load/store rules.
module tb_dmem_ext;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_ext_if if1 ();
    dmem_ext_if if3 ();

    dmem_ext #(.DEPTH(1024), .LATENCY(1)) u_l1 (.clk(clk), .rst(rst), .bus(if1.slave));
    dmem_ext #(.DEPTH(16),   .LATENCY(3)) u_l3 (.clk(clk), .rst(rst), .bus(if3.slave));

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int last_accept_cyc = 0;
    int accept_gap = 0;
    logic [31:0] last_rd;
    logic        last_err;
    logic [31:0] m1 [1024];
    logic [31:0] m3 [16];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    // Reference model: whole-word array, byte arithmetic on a 32-bit value.
    function automatic void model(input bit d3, input logic we, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic err);
        int depth;
        int w;
        int off;
        int size;
        bit legal;
        logic [31:0] word;
        logic [31:0] mask;
        logic [31:0] v;
        depth = d3 ? 16 : 1024;
        w     = int'((a / 32'd4) % 32'(depth));
        off   = int'(a % 32'd4);
        word  = d3 ? m3[w] : m1[w];
        rd    = 32'd0;
        err   = 1'b0;
        if (we) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size = (f3 % 3'd4 == 3'd0) ? 1 : ((f3 % 3'd4 == 3'd1) ? 2 : 4);
        if (!legal || (off % size) != 0) begin
            err = 1'b1;
            return;
        end
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        if (we) begin
            v = (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
            if (d3) m3[w] = v;
            else    m1[w] = v;
        end else begin
            v = (word >> (8 * off)) & mask;
            if (f3 == 3'd0 && v >= 32'd128)   v = v + 32'hFFFF_FF00;
            if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
            rd = v;
        end
    endfunction

    task automatic drive(input bit d3, input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        if (d3) begin
            if3.req_valid = v; if3.req_we = we; if3.req_funct3 = f3; if3.addr = a; if3.write_data = wd;
        end else begin
            if1.req_valid = v; if1.req_we = we; if1.req_funct3 = f3; if1.addr = a; if1.write_data = wd;
        end
    endtask

    function automatic logic rdy(input bit d3);
        return d3 ? if3.req_ready : if1.req_ready;
    endfunction
    function automatic logic rv(input bit d3);
        return d3 ? if3.resp_valid : if1.resp_valid;
    endfunction
    function automatic logic [31:0] rdat(input bit d3);
        return d3 ? if3.read_data : if1.read_data;
    endfunction
    function automatic logic rerr(input bit d3);
        return d3 ? if3.resp_err : if1.resp_err;
    endfunction

    // One complete transaction: wait for ready, accept, then check latency and response.
    task automatic run(input bit d3, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] exp_rd;
        logic        exp_err;
        int lat;
        int n;
        int cyc;
        lat = d3 ? 3 : 1;
        drive(d3, 1'b1, we, f3, a, wd);
        n = 0;
        while (rdy(d3) !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rdy(d3) !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: req_ready=%b required 1", rdy(d3));
            drive(d3, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
            return;
        end
        @(posedge clk);
        #1;
        accept_gap      = cyc_cnt - last_accept_cyc;
        last_accept_cyc = cyc_cnt;
        drive(d3, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        model(d3, we, f3, a, wd, exp_rd, exp_err);
        cyc = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (rv(d3) === 1'b1) begin
                cyc = i;
                break;
            end
            checks++;
            if (rdat(d3) !== 32'd0 || rerr(d3) !== 1'b0 || rdy(d3) !== 1'b0) begin
                errors++;
                $display("FAIL busy_outputs: read_data=%h resp_err=%b req_ready=%b required 0/0/0",
                         rdat(d3), rerr(d3), rdy(d3));
            end
        end
        checks++;
        if (cyc != lat) begin
            errors++;
            $display("FAIL latency: got %0d cycles required %0d (addr %h)", cyc, lat, a);
        end
        checks++;
        if (rdy(d3) !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_resp: req_ready=%b required 0", rdy(d3));
        end
        checks++;
        if (rerr(d3) !== exp_err) begin
            errors++;
            $display("FAIL resp_err: got %b required %b (we=%b f3=%0d addr=%h)", rerr(d3), exp_err, we, f3, a);
        end
        checks++;
        if (rdat(d3) !== exp_rd) begin
            errors++;
            $display("FAIL read_data: got %h required %h (we=%b f3=%0d addr=%h)", rdat(d3), exp_rd, we, f3, a);
        end
        last_rd  = rdat(d3);
        last_err = rerr(d3);
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (rdy(d[0]) !== 1'b0 || rv(d[0]) !== 1'b0 || rdat(d[0]) !== 32'd0 || rerr(d[0]) !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_state: ready=%b valid=%b data=%h err=%b required 0/0/0/0",
                             rdy(d[0]), rv(d[0]), rdat(d[0]), rerr(d[0]));
                end
            end
        end
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rdy(d[0]) !== 1'b1 || rv(d[0]) !== 1'b0) begin
                errors++;
                $display("FAIL ready_after_reset: ready=%b valid=%b required 1/0", rdy(d[0]), rv(d[0]));
            end
        end
    endtask

    task automatic test_lanes_and_errors();
        vec_t tbl [19] = '{
            '{1'b1, 3'd2, 32'h0, 32'hDEADBEEF, 32'h0,        1'b0},
            '{1'b0, 3'd2, 32'h0, 32'h0,        32'hDEADBEEF, 1'b0},
            '{1'b0, 3'd0, 32'h3, 32'h0,        32'hFFFFFFDE, 1'b0},
            '{1'b0, 3'd4, 32'h3, 32'h0,        32'h000000DE, 1'b0},
            '{1'b0, 3'd1, 32'h2, 32'h0,        32'hFFFFDEAD, 1'b0},
            '{1'b0, 3'd5, 32'h0, 32'h0,        32'h0000BEEF, 1'b0},
            '{1'b1, 3'd0, 32'h1, 32'h000000AA, 32'h0,        1'b0},
            '{1'b0, 3'd2, 32'h0, 32'h0,        32'hDEADAAEF, 1'b0},
            '{1'b1, 3'd2, 32'h4, 32'h0,        32'h0,        1'b0},
            '{1'b1, 3'd1, 32'h6, 32'h00001234, 32'h0,        1'b0},
            '{1'b0, 3'd2, 32'h4, 32'h0,        32'h12340000, 1'b0},
            '{1'b0, 3'd2, 32'h2, 32'h0,        32'h0,        1'b1},
            '{1'b1, 3'd1, 32'h1, 32'h0000FFFF, 32'h0,        1'b1},
            '{1'b0, 3'd2, 32'h4, 32'h0,        32'h12340000, 1'b0},
            '{1'b0, 3'd3, 32'h0, 32'h0,        32'h0,        1'b1},
            '{1'b1, 3'd4, 32'h0, 32'h00000055, 32'h0,        1'b1},
            '{1'b0, 3'd2, 32'h0, 32'h0,        32'hDEADAAEF, 1'b0},
            '{1'b0, 3'd1, 32'h1, 32'h0,        32'h0,        1'b1},
            '{1'b0, 3'd5, 32'h2, 32'h0,        32'h0000DEAD, 1'b0}
        };
        for (int i = 0; i < 19; i++) begin
            run(1'b0, tbl[i].we, tbl[i].f3, tbl[i].a, tbl[i].wd);
            checks++;
            if (last_rd !== tbl[i].rd || last_err !== tbl[i].err) begin
                errors++;
                $display("FAIL lanes_vec%0d: got data=%h err=%b required data=%h err=%b",
                         i, last_rd, last_err, tbl[i].rd, tbl[i].err);
            end
        end
    endtask

    task automatic test_reset_ignores_req();
        run(1'b0, 1'b1, 3'd2, 32'h8, 32'h11223344);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 3'd2, 32'h8, 32'hFFFFFFFF);
        rst = 1'b1;
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rv(1'b0) !== 1'b0 || rdy(1'b0) !== 1'b1) begin
            errors++;
            $display("FAIL req_during_reset: valid=%b ready=%b required 0/1", rv(1'b0), rdy(1'b0));
        end
        run(1'b0, 1'b0, 3'd2, 32'h8, 32'd0);
        checks++;
        if (last_rd !== 32'h11223344) begin
            errors++;
            $display("FAIL mem_kept_over_reset: got %h required %h", last_rd, 32'h11223344);
        end
    endtask

    task automatic test_wrap_latency3();
        run(1'b1, 1'b1, 3'd2, 32'h40, 32'hCAFEF00D);
        run(1'b1, 1'b0, 3'd2, 32'h0, 32'd0);
        checks++;
        if (last_rd !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL wrap_word0: got %h required %h", last_rd, 32'hCAFEF00D);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] dummy_rd;
        logic        dummy_err;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 3'd2, 32'h8, 32'h5A5AA5A5);
        checks++;
        if (rdy(1'b1) !== 1'b1) begin
            errors++;
            $display("FAIL mid_wait_ready: req_ready=%b required 1", rdy(1'b1));
        end
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        model(1'b1, 1'b1, 3'd2, 32'h8, 32'h5A5AA5A5, dummy_rd, dummy_err);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (rv(1'b1) !== 1'b0 || rdy(1'b1) !== 1'b1) begin
                errors++;
                $display("FAIL dropped_resp: valid=%b ready=%b required 0/1", rv(1'b1), rdy(1'b1));
            end
        end
        run(1'b1, 1'b0, 3'd2, 32'h8, 32'd0);
        checks++;
        if (last_rd !== 32'h5A5AA5A5) begin
            errors++;
            $display("FAIL store_survives_reset: got %h required %h", last_rd, 32'h5A5AA5A5);
        end
    endtask

    task automatic test_back_to_back();
        for (int d = 0; d < 2; d++) begin
            run(d[0], 1'b1, 3'd2, 32'hC, 32'h0BADF00D);
            run(d[0], 1'b0, 3'd2, 32'hC, 32'd0);
            checks++;
            if (accept_gap != (d == 1 ? 4 : 2)) begin
                errors++;
                $display("FAIL throughput: gap %0d cycles required %0d", accept_gap, (d == 1 ? 4 : 2));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 16; i++) run(1'b1, 1'b1, 3'd2, 32'(i * 4), $urandom);
        for (int i = 0; i < 64; i++) run(1'b0, 1'b1, 3'd2, 32'(i * 4), $urandom);
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) begin
                a = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
                run(1'b0, 1'($urandom), 3'($urandom), a, $urandom);
            end else begin
                run(1'b1, 1'($urandom), 3'($urandom), $urandom, $urandom);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lanes_and_errors();
        test_reset_ignores_req();
        test_wrap_latency3();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
